// File: rtl/dtmr_pwm_drv_pkg.sv
// dtmr_pwm_drv_pkg: shared state encoding, fault popcount and command width for the DTMR voter and PWM driver
package dtmr_pwm_drv_pkg;
  localparam int CMD_L_DEF = 4;
  typedef enum logic [1:0] {RUN, DEAD, SAFE} drv_state_t;
  function automatic logic [1:0] popcount3(input logic [2:0] f);
    return {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
  endfunction
endpackage

// File: rtl/dtmr_pwm_core.sv
// dtmr_pwm_core: prescaler, period counter and duty latch producing the raw active level and period boundary pulse
module dtmr_pwm_core
  import dtmr_pwm_drv_pkg::*;
#(
  parameter int CMD_L = CMD_L_DEF,
  parameter int PRESC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             load,
  input  logic [CMD_L-1:0] speed_cmd,
  output logic             wrap,
  output logic             active,
  output logic             period_start
);
  localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
  localparam logic [CMD_L-1:0] CMAX = CMD_L'((1 << CMD_L) - 2);
  logic [PW-1:0] presc;
  logic [CMD_L-1:0] cnt, duty;
  logic tick;
  assign tick = presc == PW'(PRESC - 1);
  assign wrap = tick && cnt == CMAX;
  assign active = cnt < duty;
  // duty only moves at a period boundary or on restart after dead time, so the output never sees a runt pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cnt <= '0;
      duty <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= load || (!freeze && wrap);
      if (load) begin
        presc <= '0;
        cnt <= '0;
        duty <= speed_cmd;
      end else if (!freeze) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) duty <= speed_cmd;
      end
    end
  end
endmodule

// File: rtl/dtmr_pwm_drv.sv
// dtmr_pwm_drv: H-bridge PWM driver with dead time and latched fault safe state; DTMR_FAULT_CNT_EN adds a single-fault counter
module dtmr_pwm_drv
  import dtmr_pwm_drv_pkg::*;
#(
  parameter int CMD_L = CMD_L_DEF,
  parameter int PRESC = 1,
  parameter int DEAD_CYC = 16,
  parameter int FLT_PERS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_L-1:0] speed_cmd,
  input  logic [CMD_L-1:0] dir_cmd,
  input  logic [2:0]       fault,
  input  logic             fault_clr,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic             dir_o,
  output logic             safe,
  output logic             period_start
`ifdef DTMR_FAULT_CNT_EN
  ,
  output logic [7:0]       fault_cnt
`endif
);
  localparam int DW = DEAD_CYC > 1 ? $clog2(DEAD_CYC) : 1;
  localparam int PSW = $clog2(FLT_PERS + 1);
  drv_state_t state, state_nxt;
  logic [DW-1:0] dcnt;
  logic [PSW-1:0] pers, pers_nxt;
  logic [1:0] pc;
  logic multi, go_safe, clr_ok, rev, dead_done, load, freeze, wrap, active, drive;
  logic unused_dir;
  assign unused_dir = ^dir_cmd[CMD_L-2:0];
  dtmr_pwm_core #(.CMD_L(CMD_L), .PRESC(PRESC)) u_core (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .load(load),
    .speed_cmd(speed_cmd),
    .wrap(wrap),
    .active(active),
    .period_start(period_start)
  );
  // next state with precedence SAFE entry > fault clear > direction reversal > end of dead time
  always_comb begin
    pc = popcount3(fault);
    multi = pc >= 2'd2;
    pers_nxt = multi ? (pers == PSW'(FLT_PERS) ? pers : pers + 1'b1) : '0;
    go_safe = pers_nxt == PSW'(FLT_PERS);
    clr_ok = state == SAFE && fault_clr && !multi;
    rev = state == RUN && wrap && dir_cmd[CMD_L-1] != dir_o;
    dead_done = state == DEAD && dcnt == DW'(DEAD_CYC - 1);
    state_nxt = go_safe ? SAFE : (clr_ok || rev) ? DEAD : dead_done ? RUN : state;
    load = state == DEAD && state_nxt == RUN;
    freeze = state_nxt != RUN;
    drive = state_nxt == RUN && !load && active;
  end
  // state, dead-time and persistence registers plus the gated bridge outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pers <= '0;
      dcnt <= '0;
      dir_o <= 1'b0;
      pwm_a <= 1'b0;
      pwm_b <= 1'b0;
      safe <= 1'b0;
    end else begin
      state <= state_nxt;
      pers <= pers_nxt;
      dcnt <= (state == DEAD && state_nxt == DEAD) ? dcnt + 1'b1 : '0;
      dir_o <= load ? dir_cmd[CMD_L-1] : dir_o;
      pwm_a <= drive && !dir_o;
      pwm_b <= drive && dir_o;
      safe <= state_nxt == SAFE;
    end
  end
`ifdef DTMR_FAULT_CNT_EN
  // saturating count of cycles with exactly one module disagreeing, cleared by an accepted fault clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_cnt <= '0;
    else fault_cnt <= clr_ok ? '0 : (pc == 2'd1 && fault_cnt != 8'hff) ? fault_cnt + 1'b1 : fault_cnt;
  end
`endif
endmodule

// File: tb/tb_dtmr_pwm_drv.sv
// tb_dtmr_pwm_drv: directed self-checking bench for dtmr_pwm_drv at CMD_L=4, PRESC=1, DEAD_CYC=16, FLT_PERS=2
module tb_dtmr_pwm_drv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] speed_cmd = '0;
  logic [3:0] dir_cmd = '0;
  logic [2:0] fault = '0;
  logic fault_clr = 1'b0;
  logic pwm_a, pwm_b, dir_o, safe, period_start;
  int total = 0;
  int bad = 0;
  int n;
`ifdef DTMR_FAULT_CNT_EN
  logic [7:0] fault_cnt;
`endif
  dtmr_pwm_drv dut (
    .clk(clk),
    .rst(rst),
    .speed_cmd(speed_cmd),
    .dir_cmd(dir_cmd),
    .fault(fault),
    .fault_clr(fault_clr),
    .pwm_a(pwm_a),
    .pwm_b(pwm_b),
    .dir_o(dir_o),
    .safe(safe),
    .period_start(period_start)
`ifdef DTMR_FAULT_CNT_EN
    ,
    .fault_cnt(fault_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic wait_ps(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < 100);
  endtask
  task automatic measure(input string tag, input int ea, input int eb, input int el);
    int ha = 0, hb = 0, k = 0;
    do begin
      @(negedge clk);
      k++;
      ha += int'(pwm_a);
      hb += int'(pwm_b);
      chk({tag, "_ovl"}, int'(pwm_a & pwm_b), 0);
    end while (!period_start && k < 60);
    chk({tag, "_a"}, ha, ea);
    chk({tag, "_b"}, hb, eb);
    chk({tag, "_len"}, k, el);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_a", int'(pwm_a), 0);
    chk("rst_b", int'(pwm_b), 0);
    chk("rst_dir", int'(dir_o), 0);
    chk("rst_safe", int'(safe), 0);
    chk("rst_ps", int'(period_start), 0);
`ifdef DTMR_FAULT_CNT_EN
    chk("rst_fcnt", int'(fault_cnt), 0);
`endif
    rst = 1'b0;
    speed_cmd = 4'd5;
    wait_ps(n);
    chk("first_ps", n, 15);
    measure("d5", 5, 0, 15);
    speed_cmd = 4'd12;
    measure("mid_keep5", 5, 0, 15);
    speed_cmd = 4'd15;
    measure("d12", 12, 0, 15);
    speed_cmd = 4'd0;
    measure("d15", 15, 0, 15);
    speed_cmd = 4'd10;
    measure("d0", 0, 0, 15);
    dir_cmd = 4'h8;
    measure("rev_dead", 10, 0, 31);
    chk("rev_dir", int'(dir_o), 1);
    measure("rev_d10", 0, 10, 15);
    fault = 3'b011;
    @(negedge clk);
    fault = 3'b000;
    @(negedge clk);
    chk("f1clk_safe", int'(safe), 0);
    fault = 3'b110;
    @(negedge clk);
    chk("f_pers1", int'(safe), 0);
    @(negedge clk);
    chk("f_safe", int'(safe), 1);
    chk("f_safe_a", int'(pwm_a), 0);
    chk("f_safe_b", int'(pwm_b), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
    chk("clr_ign", int'(safe), 1);
    chk("clr_ign_b", int'(pwm_b), 0);
    fault = 3'b000;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_ok", int'(safe), 0);
    chk("clr_dead_b", int'(pwm_b), 0);
    wait_ps(n);
    chk("clr_dead_len", n, 16);
    measure("post_safe", 0, 10, 15);
    repeat (3) @(negedge clk);
    chk("mid_b_hi", int'(pwm_b), 1);
    rst = 1'b1;
    #1;
    chk("mrst_b", int'(pwm_b), 0);
    chk("mrst_dir", int'(dir_o), 0);
    @(negedge clk);
    speed_cmd = 4'd7;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("dead_a", int'(pwm_a), 0);
    chk("dead_ps", int'(period_start), 0);
    rst = 1'b1;
    #1;
    chk("drst_a", int'(pwm_a), 0);
    chk("drst_b", int'(pwm_b), 0);
    chk("drst_dir", int'(dir_o), 0);
    chk("drst_safe", int'(safe), 0);
    @(negedge clk);
    dir_cmd = 4'h0;
    rst = 1'b0;
    wait_ps(n);
    chk("rel_ps", n, 15);
    measure("rel_d7", 7, 0, 15);
`ifdef DTMR_FAULT_CNT_EN
    fault = 3'b100;
    repeat (300) @(negedge clk);
    chk("fcnt_sat", int'(fault_cnt), 255);
    chk("fcnt_nosafe", int'(safe), 0);
    fault = 3'b111;
    repeat (2) @(negedge clk);
    chk("f111_safe", int'(safe), 1);
    fault = 3'b000;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fcnt_clr", int'(fault_cnt), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
